// File: rtl/bnn_param_loader_pkg.sv
// Shared types and sizes for the BNN parameter loader and its consumer.
// param_t is the word type that BNN imports for its wt/b inputs.
package bnn_param_loader_pkg;

    localparam int W     = 16;
    localparam int N_WT  = 6;
    localparam int N_B   = 3;
    localparam int N_TOT = N_WT + N_B;
    localparam int IDX_W = $clog2(N_TOT);

    typedef logic signed [W-1:0] param_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } load_state_t;

endpackage

// File: rtl/bnn_param_loader_if.sv
// Valid/ready word stream from the parameter source into the loader.
// The master side drives words; the slave side drives in_ready.
interface bnn_param_loader_if;
    import bnn_param_loader_pkg::*;

    logic   start;
    logic   in_valid;
    logic   in_ready;
    param_t in_data;
    logic   in_last;

    modport master (
        output start,
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  start,
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/bnn_param_loader.sv
// Stages a framed stream of weights then biases in shadow registers and
// commits the whole set to wt/b in one edge once the frame closes correctly.
//
// state  | meaning
// IDLE   | waiting for start; stream ignored
// LOAD   | accepting words into shadow[idx]
// COMMIT | copying shadow into wt/b, raising params_valid
module bnn_param_loader
    import bnn_param_loader_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    bnn_param_loader_if.slave bus,
    output param_t            wt [N_WT],
    output param_t            b  [N_B],
    output logic              params_valid,
    output logic              busy,
    output logic              err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TOT - 1);

    load_state_t      state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    param_t           shadow_q [N_TOT];
    param_t           wt_q     [N_WT];
    param_t           b_q      [N_B];
    logic             params_valid_q;
    logic             have_set_q;
    logic             busy_q;
    logic             err_q;
    logic             in_ready_q;

    logic xfer;
    logic frame_ok;
    logic frame_err;

    // in_ready_q is only set in LOAD, so xfer implies LOAD
    assign xfer      = bus.in_valid && in_ready_q;
    assign frame_ok  = xfer && (idx_q == LAST_IDX) && bus.in_last;
    assign frame_err = xfer && ((idx_q == LAST_IDX) != bus.in_last);
    assign idx_d     = idx_q + 1'b1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            params_valid_q <= 1'b0;
            have_set_q     <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
            in_ready_q     <= 1'b0;
            for (int i = 0; i < N_TOT; i++) shadow_q[i] <= '0;
            for (int i = 0; i < N_WT; i++)  wt_q[i]     <= '0;
            for (int i = 0; i < N_B; i++)   b_q[i]      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= LOAD;
                        idx_q      <= '0;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.start) begin
                        idx_q <= '0;
                        err_q <= 1'b0;
                    end else if (xfer) begin
                        shadow_q[idx_q] <= bus.in_data;
                        if (idx_q == '0) params_valid_q <= 1'b0;
                        if (frame_ok) begin
                            state_q    <= COMMIT;
                            in_ready_q <= 1'b0;
                            idx_q      <= '0;
                        end else if (frame_err) begin
                            // old wt/b are untouched, so validity reverts
                            state_q        <= IDLE;
                            in_ready_q     <= 1'b0;
                            busy_q         <= 1'b0;
                            err_q          <= 1'b1;
                            idx_q          <= '0;
                            params_valid_q <= have_set_q;
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < N_WT; i++) wt_q[i] <= shadow_q[i];
                    for (int i = 0; i < N_B; i++)  b_q[i]  <= shadow_q[N_WT + i];
                    params_valid_q <= 1'b1;
                    have_set_q     <= 1'b1;
                    busy_q         <= 1'b0;
                    state_q        <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign wt            = wt_q;
    assign b             = b_q;
    assign params_valid  = params_valid_q;
    assign busy          = busy_q;
    assign err           = err_q;

endmodule

// File: tb/tb_bnn_param_loader.sv
// Directed bench for bnn_param_loader: framed loads, throttling, framing
// errors, restart and asynchronous reset, with a queue of expected sets.
module tb_bnn_param_loader;
    import bnn_param_loader_pkg::*;

    typedef struct {
        param_t w [N_TOT];
    } frame_t;

    logic   Clk;
    logic   Reset_n;
    param_t wt [N_WT];
    param_t b  [N_B];
    logic   params_valid;
    logic   busy;
    logic   err;

    int total = 0;
    int bad   = 0;

    frame_t sb [$];

    bnn_param_loader_if bus ();

    bnn_param_loader dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .bus          (bus.slave),
        .wt           (wt),
        .b            (b),
        .params_valid (params_valid),
        .busy         (busy),
        .err          (err)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives words[0..nwords-1]; in_last on index last_at (-1: never).
    task automatic send_frame(input param_t words [N_TOT], input int nwords,
                              input int last_at, input bit throttle,
                              output int busy_lows);
        bit tog;
        bit done;
        bit rdy;
        tog       = 1'b0;
        busy_lows = 0;
        for (int k = 0; k < nwords; k++) begin
            done = 1'b0;
            for (int c = 0; c < 20 && !done; c++) begin
                bus.in_valid = throttle ? tog : 1'b1;
                bus.in_data  = words[k];
                bus.in_last  = (k == last_at);
                tog          = ~tog;
                rdy          = bus.in_ready;
                if (!busy) busy_lows++;
                step();
                if (bus.in_valid && rdy) done = 1'b1;
            end
            if (!done) chk("xfer_timeout", 0, 1);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_set(input string tag);
        frame_t f;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
            return;
        end
        f = sb.pop_front();
        for (int i = 0; i < N_WT; i++) chk({tag, "_wt"}, wt[i], f.w[i]);
        for (int i = 0; i < N_B; i++)  chk({tag, "_b"}, b[i], f.w[N_WT + i]);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        frame_t fa, fb, fc, f7;
        param_t nom [N_TOT];
        int lows;

        nom = '{16'sd20, 16'sd20, -16'sd20, -16'sd20, 16'sd20, 16'sd20,
                -16'sd10, 16'sd10, -16'sd30};
        fa.w = nom;
        for (int i = 0; i < N_TOT; i++) begin
            fb.w[i] = (i % 2 == 0) ? param_t'(100 + i) : param_t'(-(100 + i));
            fc.w[i] = param_t'(16'h5A00 + i);
            f7.w[i] = 16'sd7;
        end

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        Reset_n      = 1'b0;
        #12;
        chk("rst_pv", params_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_wt0", wt[0], 0);
        chk("rst_b2", b[2], 0);
        Reset_n = 1'b1;
        step();

        // stream ignored while idle
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        step();
        step();
        chk("idle_ready", bus.in_ready, 0);
        chk("idle_busy", busy, 0);
        chk("idle_pv", params_valid, 0);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;

        // nominal back-to-back load
        sb.push_back(fa);
        pulse_start();
        chk("nom_ready_after_start", bus.in_ready, 1);
        chk("nom_busy_after_start", busy, 1);
        send_frame(fa.w, N_TOT, N_TOT - 1, 1'b0, lows);
        chk("nom_busy_lows", lows, 0);
        chk("nom_commit_busy", busy, 1);
        chk("nom_commit_ready", bus.in_ready, 0);
        chk("nom_commit_pv", params_valid, 0);
        step();
        chk("nom_pv", params_valid, 1);
        chk("nom_busy_done", busy, 0);
        chk("nom_err", err, 0);
        check_set("nom");

        // throttled source
        sb.push_back(fb);
        pulse_start();
        send_frame(fb.w, N_TOT, N_TOT - 1, 1'b1, lows);
        chk("thr_busy_lows", lows, 0);
        chk("thr_commit_busy", busy, 1);
        step();
        chk("thr_pv", params_valid, 1);
        chk("thr_busy_done", busy, 0);
        check_set("thr");

        // early in_last on word 5: old set kept
        sb.push_back(fb);
        pulse_start();
        send_frame(fc.w, 5, 4, 1'b0, lows);
        chk("early_err", err, 1);
        chk("early_busy", busy, 0);
        chk("early_ready", bus.in_ready, 0);
        chk("early_pv", params_valid, 1);
        check_set("early");

        // missing in_last on word 9: no commit
        sb.push_back(fb);
        pulse_start();
        chk("miss_err_cleared", err, 0);
        send_frame(fc.w, N_TOT, -1, 1'b0, lows);
        chk("miss_err", err, 1);
        chk("miss_busy", busy, 0);
        step();
        step();
        chk("miss_pv", params_valid, 1);
        chk("miss_err_sticky", err, 1);
        check_set("miss");

        // restart after 4 words, with a same-cycle word that must be dropped
        pulse_start();
        chk("rs_err_cleared", err, 0);
        send_frame(fc.w, 4, -1, 1'b0, lows);
        chk("rs_stale_pv", params_valid, 0);
        chk("rs_ready", bus.in_ready, 1);
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'sd99;
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        sb.push_back(f7);
        send_frame(f7.w, N_TOT, N_TOT - 1, 1'b0, lows);
        chk("rs_commit_busy", busy, 1);
        step();
        chk("rs_pv", params_valid, 1);
        chk("rs_err", err, 0);
        check_set("rs");

        // asynchronous reset mid-load
        pulse_start();
        send_frame(fc.w, 3, -1, 1'b0, lows);
        Reset_n = 1'b0;
        #1;
        chk("arst_pv", params_valid, 0);
        chk("arst_ready", bus.in_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_wt0", wt[0], 0);
        chk("arst_wt5", wt[5], 0);
        chk("arst_b0", b[0], 0);
        chk("arst_err", err, 0);
        step();
        #2;
        Reset_n = 1'b1;
        step();
        chk("arst_idle_ready", bus.in_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
